apb_master_ctrl: RTL and testbench
==================================

APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of PWDATA, PRDATA, req_wdata and rd_data.
REQ-002 Parameter ADDR_WIDTH, default 8: width of PADDR and req_addr; ADDR_WIDTH SHALL be at least 3.
REQ-003 Parameter TIMEOUT, default 16: maximum wait cycles in ACCESS before abort; TIMEOUT SHALL be at least 2.
REQ-004 Clocking and reset SHALL be as follows: one clock; reset is asynchronous and active-high.
REQ-005 PCLK  input  1  clock; all state SHALL change on the rising edge.
REQ-006 PRESET  input  1  asynchronous, active-high reset.
REQ-007 req_valid  input  1  transfer request from the local requester.
REQ-008 req_ready  output  1  controller can accept a request this cycle.
REQ-009 req_write  input  1  direction of the request: 1 is write, 0 is read.
REQ-010 req_addr  input  ADDR_WIDTH  byte address of the request.
REQ-011 req_wdata  input  DATA_WIDTH  write data of the request.
REQ-012 PADDR  output  ADDR_WIDTH  APB address.
REQ-013 PWRITE  output  1  APB direction.
REQ-014 PWDATA  output  DATA_WIDTH  APB write data.
REQ-015 PSEL  output  4  one-hot slave select; bit k selects slave k+1.
REQ-016 PENABLE  output  1  APB access phase.
REQ-017 mux_sel  output  2  slave index driven to the read-data/ready multiplexer.
REQ-018 PRDATA  input  DATA_WIDTH  muxed read data from the multiplexer.
REQ-019 PREADY  input  1  muxed ready from the multiplexer.
REQ-020 rd_data  output  DATA_WIDTH  captured read data.
REQ-021 done  output  1  one-cycle completion pulse.
REQ-022 error  output  1  timeout flag, valid while done is 1.

Function
REQ-023 The controller SHALL implement three states: IDLE, SETUP and ACCESS.
REQ-024 req_ready SHALL be 1 in IDLE and 0 in SETUP and ACCESS (combinational from state).
REQ-025 A request SHALL be accepted on the edge where req_valid and req_ready are both 1; req_addr, req_write and req_wdata SHALL be registered into PADDR, PWRITE and PWDATA on that edge, and the state SHALL become SETUP.
REQ-026 Slave index idx SHALL be req_addr[ADDR_WIDTH-1:ADDR_WIDTH-2], registered at acceptance; mux_sel SHALL equal idx and SHALL stay stable until the next acceptance.
REQ-027 In SETUP, PSEL[idx] SHALL be 1 and PENABLE SHALL be 0; the next state SHALL be ACCESS unconditionally.
REQ-028 In ACCESS, PSEL[idx] and PENABLE SHALL both be 1; PADDR, PWRITE and PWDATA SHALL be held.
REQ-029 In ACCESS with PREADY=1: next state SHALL be IDLE; done SHALL be 1 for the next cycle with error=0; if PWRITE=0, rd_data SHALL capture PRDATA on that edge.
REQ-030 Wait counter: cleared on entry to ACCESS, incremented on each ACCESS cycle with PREADY=0.
REQ-031 When the counter reaches TIMEOUT-1 with PREADY still 0, the controller SHALL abort: next state IDLE, done=1 and error=1 for one cycle, rd_data unchanged.
REQ-032 If PREADY=1 in the same cycle the timeout would fire, the transfer SHALL complete normally per REQ-029.
REQ-033 In IDLE, PSEL SHALL be 0 and PENABLE SHALL be 0; PADDR, PWRITE, PWDATA and mux_sel SHALL hold their last values.
REQ-034 done and error SHALL be registered and SHALL be 0 in every cycle other than the completion pulse.
REQ-035 Back-to-back: a request present during the done cycle SHALL be accepted on that edge (IDLE), giving a minimum transfer period of 3 cycles.
REQ-036 PRDATA and PREADY SHALL be ignored outside ACCESS.

Reset
REQ-037 While PRESET is 1, the controller SHALL be in IDLE and PSEL, PENABLE, PADDR, PWRITE, PWDATA, mux_sel, rd_data, done, error and the wait counter SHALL all be 0, immediately and without waiting for a clock edge.
REQ-038 Reset asserted mid-transfer SHALL drop PSEL and PENABLE asynchronously; the transfer SHALL be lost with no done pulse; after release, the first edge SHALL see req_ready=1.

Verification
REQ-039 Write, zero wait: addr=0x45, wdata=0xA5 with PREADY tied 1 -> PSEL=0010 (SETUP), then PENABLE=1 for 1 cycle, done=1/error=0 on the next cycle, mux_sel=01.
REQ-040 Read, 2 waits: addr=0xC0, PREADY low 2 ACCESS cycles then high with PRDATA=0x3C -> PSEL=1000, mux_sel=11, rd_data=0x3C, done pulse, total 5 cycles from acceptance.
REQ-041 Timeout: TIMEOUT=4, PREADY held 0 -> abort after 4 ACCESS cycles, done=1 and error=1 for 1 cycle, rd_data unchanged, PSEL=0 afterward.
REQ-042 Back-to-back: req_valid held high with addresses 0x00 then 0x80 -> second acceptance in the done cycle, PSEL sequence 0001 then 0100, no idle gap beyond the done cycle.
REQ-043 Reset mid-ACCESS: assert PRESET with PENABLE=1 -> PSEL, PENABLE and done go 0 immediately; after release, a new request completes normally.
REQ-044 Timeout boundary: TIMEOUT=4 with PREADY rising in the 4th ACCESS cycle -> normal completion, error=0.

Source files
------------

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl
//   APB master that turns single requests from a local requester into one
//   APB transfer (SETUP then ACCESS). The top two address bits select one of
//   four slaves. A transfer ends when PREADY is seen or when the slave keeps
//   PREADY low for TIMEOUT ACCESS cycles.
//
// Ports
//   PCLK, PRESET          clock, asynchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_write/addr/wdata  request direction, byte address, write data
//   PADDR/PWRITE/PWDATA   APB address phase signals, held for the transfer
//   PSEL[3:0]/PENABLE     one-hot slave select and access-phase strobe
//   mux_sel               slave index for the external PRDATA/PREADY mux
//   PRDATA/PREADY         muxed slave response, used only in ACCESS
//   rd_data               last read data captured on a completed read
//   done/error            one-cycle completion pulse, error = timeout abort
module apb_master_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic [3:0]            PSEL,
    output logic                  PENABLE,
    output logic [1:0]            mux_sel,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  done,
    output logic                  error
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic                    pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [3:0]              psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic [1:0]              idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   rd_q, rd_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic [CW-1:0]           cnt_q, cnt_d;

    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        idx_d     = idx_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        error_d   = 1'b0;

        case (state_q)
            IDLE: begin
                psel_d    = '0;
                penable_d = 1'b0;
                if (req_valid) begin
                    state_d  = SETUP;
                    paddr_d  = req_addr;
                    pwrite_d = req_write;
                    pwdata_d = req_wdata;
                    idx_d    = req_addr[ADDR_WIDTH-1 -: 2];
                    psel_d   = 4'b0001 << req_addr[ADDR_WIDTH-1 -: 2];
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ACCESS: begin
                // PREADY wins over a timeout that would fire in the same cycle
                if (PREADY) begin
                    state_d   = IDLE;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    done_d    = 1'b1;
                    if (!pwrite_q) begin
                        rd_d = PRDATA;
                    end
                end else if (cnt_q == LAST_WAIT) begin
                    state_d   = IDLE;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    done_d    = 1'b1;
                    error_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                psel_d    = '0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= IDLE;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            idx_q     <= '0;
            rd_q      <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            idx_q     <= idx_d;
            rd_q      <= rd_d;
            done_q    <= done_d;
            error_q   <= error_d;
            cnt_q     <= cnt_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign mux_sel   = idx_q;
    assign rd_data   = rd_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb_apb_master_ctrl
//   Directed scenarios with literal expectations followed by a randomized
//   run, all compared every cycle against a transfer-level model.
module tb_apb_master_ctrl;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int TO = 4;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [AW-1:0] PADDR;
    logic          PWRITE;
    logic [DW-1:0] PWDATA;
    logic [3:0]    PSEL;
    logic          PENABLE;
    logic [1:0]    mux_sel;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic [DW-1:0] rd_data;
    logic          done;
    logic          error;

    int checks = 0;
    int errors = 0;

    apb_master_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .TIMEOUT   (TO)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .PADDR    (PADDR),
        .PWRITE   (PWRITE),
        .PWDATA   (PWDATA),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .mux_sel  (mux_sel),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .rd_data  (rd_data),
        .done     (done),
        .error    (error)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transfer-level model: m_age counts cycles since acceptance
    // (1 = address phase, n >= 2 = (n-1)th access cycle).
    bit          m_active = 0;
    int          m_age    = 0;
    logic [AW-1:0] m_addr = '0;
    logic        m_write  = 0;
    logic [DW-1:0] m_wdata = '0;
    logic [1:0]  m_idx    = '0;
    logic [DW-1:0] m_rd   = '0;
    logic        m_done   = 0;
    logic        m_err    = 0;

    always @(posedge PCLK) begin
        if (PRESET) begin
            m_active = 0; m_age = 0; m_addr = '0; m_write = 0; m_wdata = '0;
            m_idx = '0; m_rd = '0; m_done = 0; m_err = 0;
        end else begin
            m_done = 0;
            m_err  = 0;
            if (!m_active) begin
                if (req_valid) begin
                    m_active = 1;
                    m_age    = 1;
                    m_addr   = req_addr;
                    m_write  = req_write;
                    m_wdata  = req_wdata;
                    m_idx    = 2'(req_addr / (1 << (AW - 2)));
                end
            end else if (m_age == 1) begin
                m_age = 2;
            end else if (PREADY) begin
                m_done = 1;
                if (!m_write) m_rd = PRDATA;
                m_active = 0;
            end else if (m_age - 1 == TO) begin
                m_done = 1;
                m_err  = 1;
                m_active = 0;
            end else begin
                m_age++;
            end
        end
    end

    bit cmp_en = 0;

    always @(posedge PCLK) begin
        #1;
        if (cmp_en) begin
            chk("m_ready",   32'(req_ready), 32'(!m_active));
            chk("m_psel",    32'(PSEL),      m_active ? 32'(1 << m_idx) : 32'h0);
            chk("m_penable", 32'(PENABLE),   32'(m_active && m_age >= 2));
            chk("m_paddr",   32'(PADDR),     32'(m_addr));
            chk("m_pwrite",  32'(PWRITE),    32'(m_write));
            chk("m_pwdata",  32'(PWDATA),    32'(m_wdata));
            chk("m_mux_sel", 32'(mux_sel),   32'(m_idx));
            chk("m_rd_data", 32'(rd_data),   32'(m_rd));
            chk("m_done",    32'(done),      32'(m_done));
            chk("m_error",   32'(error),     32'(m_err));
        end
    end

    initial begin
        int thr;
        PRESET = 0; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
        PRDATA = '0; PREADY = 0;
        #1 PRESET = 1;
        #1;
        chk("rst_psel",    32'(PSEL),      32'h0);
        chk("rst_penable", 32'(PENABLE),   32'h0);
        chk("rst_paddr",   32'(PADDR),     32'h0);
        chk("rst_mux_sel", 32'(mux_sel),   32'h0);
        chk("rst_rd_data", 32'(rd_data),   32'h0);
        chk("rst_done",    32'(done),      32'h0);
        chk("rst_ready",   32'(req_ready), 32'h1);
        cmp_en = 1;
        @(negedge PCLK);
        @(negedge PCLK);
        PRESET = 0;

        // Write, zero wait
        @(negedge PCLK);
        req_valid = 1; req_write = 1; req_addr = 8'h45; req_wdata = 8'hA5; PREADY = 1;
        @(negedge PCLK);
        chk("wr_setup_psel",    32'(PSEL),    32'h2);
        chk("wr_setup_penable", 32'(PENABLE), 32'h0);
        chk("wr_mux_sel",       32'(mux_sel), 32'h1);
        chk("wr_paddr",         32'(PADDR),   32'h45);
        chk("wr_pwdata",        32'(PWDATA),  32'hA5);
        req_valid = 0;
        @(negedge PCLK);
        chk("wr_access_penable", 32'(PENABLE), 32'h1);
        chk("wr_access_psel",    32'(PSEL),    32'h2);
        @(negedge PCLK);
        chk("wr_done",      32'(done),  32'h1);
        chk("wr_error",     32'(error), 32'h0);
        chk("wr_idle_psel", 32'(PSEL),  32'h0);

        // Read with two wait states
        req_valid = 1; req_write = 0; req_addr = 8'hC0; PREADY = 0; PRDATA = 8'h77;
        @(negedge PCLK);
        chk("rd_psel",    32'(PSEL),    32'h8);
        chk("rd_mux_sel", 32'(mux_sel), 32'h3);
        req_valid = 0;
        @(negedge PCLK);
        chk("rd_wait1_penable", 32'(PENABLE), 32'h1);
        @(negedge PCLK);
        @(negedge PCLK);
        PREADY = 1; PRDATA = 8'h3C;
        @(negedge PCLK);
        chk("rd_done",    32'(done),    32'h1);
        chk("rd_error",   32'(error),   32'h0);
        chk("rd_rd_data", 32'(rd_data), 32'h3C);
        PREADY = 0;

        // Timeout: PREADY never rises
        req_valid = 1; req_write = 0; req_addr = 8'h40; PRDATA = 8'hFF;
        @(negedge PCLK);
        req_valid = 0;
        repeat (4) @(negedge PCLK);
        chk("to_a4_penable", 32'(PENABLE), 32'h1);
        @(negedge PCLK);
        chk("to_done",    32'(done),    32'h1);
        chk("to_error",   32'(error),   32'h1);
        chk("to_rd_data", 32'(rd_data), 32'h3C);
        chk("to_psel",    32'(PSEL),    32'h0);
        @(negedge PCLK);
        chk("to_done_clr",  32'(done),  32'h0);
        chk("to_error_clr", 32'(error), 32'h0);

        // PREADY rises in the last allowed access cycle
        req_valid = 1; req_write = 0; req_addr = 8'h40;
        @(negedge PCLK);
        req_valid = 0;
        repeat (4) @(negedge PCLK);
        PREADY = 1; PRDATA = 8'h5A;
        @(negedge PCLK);
        chk("tb_done",    32'(done),    32'h1);
        chk("tb_error",   32'(error),   32'h0);
        chk("tb_rd_data", 32'(rd_data), 32'h5A);

        // Back-to-back with req_valid held
        PREADY = 1; req_valid = 1; req_write = 1; req_addr = 8'h00; req_wdata = 8'h11;
        @(negedge PCLK);
        chk("b2b_psel1", 32'(PSEL), 32'h1);
        req_addr = 8'h80; req_wdata = 8'h22;
        @(negedge PCLK);
        chk("b2b_penable1", 32'(PENABLE), 32'h1);
        @(negedge PCLK);
        chk("b2b_done1",  32'(done),      32'h1);
        chk("b2b_ready1", 32'(req_ready), 32'h1);
        @(negedge PCLK);
        chk("b2b_psel2",    32'(PSEL),    32'h4);
        chk("b2b_mux_sel2", 32'(mux_sel), 32'h2);
        chk("b2b_done_clr", 32'(done),    32'h0);
        req_valid = 0;
        @(negedge PCLK);
        @(negedge PCLK);
        chk("b2b_done2", 32'(done), 32'h1);

        // Reset in the middle of ACCESS
        PREADY = 0; req_valid = 1; req_write = 1; req_addr = 8'h20; req_wdata = 8'h33;
        @(negedge PCLK);
        req_valid = 0;
        @(negedge PCLK);
        chk("mr_pre_penable", 32'(PENABLE), 32'h1);
        PRESET = 1;
        #1;
        chk("mr_psel",    32'(PSEL),      32'h0);
        chk("mr_penable", 32'(PENABLE),   32'h0);
        chk("mr_done",    32'(done),      32'h0);
        chk("mr_ready",   32'(req_ready), 32'h1);
        @(negedge PCLK);
        PRESET = 0;
        #1;
        chk("mr_ready_after", 32'(req_ready), 32'h1);
        req_valid = 1; req_write = 1; req_addr = 8'h60; req_wdata = 8'h99; PREADY = 1;
        @(negedge PCLK);
        chk("mr_new_psel", 32'(PSEL), 32'h2);
        req_valid = 0;
        @(negedge PCLK);
        @(negedge PCLK);
        chk("mr_new_done",  32'(done),  32'h1);
        chk("mr_new_error", 32'(error), 32'h0);

        // Randomized traffic, model-checked every cycle
        thr = 4;
        for (int i = 0; i < 3000; i++) begin
            @(negedge PCLK);
            if (i % 100 == 0) thr = $urandom_range(1, 7);
            if (PRESET) begin
                PRESET = 0;
            end else if ($urandom_range(0, 299) == 0) begin
                PRESET = 1;
            end
            req_valid = ($urandom_range(0, 3) != 0);
            req_write = $urandom_range(0, 1) == 1;
            req_addr  = 8'($urandom);
            req_wdata = 8'($urandom);
            PRDATA    = 8'($urandom);
            PREADY    = ($urandom_range(0, 7) < thr);
        end
        req_valid = 0;
        PRESET = 0;
        repeat (10) @(negedge PCLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
